crc16_rx_strip: RTL and testbench

Receive-side counterpart of the 32-bit parallel CRC16 (x^16+x^12+x^5+1, 0x1021, MSB-first) frame protector. Accepts 32-bit frames whose last word carries {data[15:0], crc[15:0]}, and verifies the CRC. Stores each frame in a store-and-forward buffer and releases it downstream only once complete, with the CRC field stripped. Sits between the frame receiver/deframer and the payload consumer.

---
 rtl/crc16_rx_strip.sv | 199 +++++++++++++++++++
 tb/tb_crc16_rx_strip.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_rx_strip.sv
// crc16_rx_strip
//   Receive-side CRC16 checker (x^16+x^12+x^5+1, MSB-first) with a
//   store-and-forward frame buffer. Each frame's last word carries
//   {data[15:0], crc[15:0]}. A frame is released downstream only after it
//   is complete, and the CRC field is replaced by zeros.
//
//   Optional feature macro: CRC_RX_DROP_BAD_EN
//     defined   : CRC-failing frames are rolled back and counted in DropCnt.
//     undefined : CRC-failing frames are forwarded, with DoutErr=1 on the last word.
//
// Ports
//   clk, RstN          clock, synchronous active-low reset
//   RegIni[15:0]       CRC seed, taken on the first beat of each frame
//   DinNd/Din/DinLast  input beat (no backpressure)
//   DoutNd/DoutRdy     output handshake
//   Dout/DoutKeep/DoutLast/DoutErr  output word and sideband
//   FrameOk/FrameBad/Overflow       one-cycle status pulses
//   DropCnt[15:0]      saturating count of discarded frames
module crc16_rx_strip #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        clk,
  input  logic        RstN,
  input  logic [15:0] RegIni,
  input  logic        DinNd,
  input  logic [31:0] Din,
  input  logic        DinLast,
  output logic        DoutNd,
  input  logic        DoutRdy,
  output logic [31:0] Dout,
  output logic [3:0]  DoutKeep,
  output logic        DoutLast,
  output logic        DoutErr,
  output logic        FrameOk,
  output logic        FrameBad,
  output logic        Overflow,
  output logic [15:0] DropCnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE, FRAME, DISCARD, CHECK} state_t;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d, crc_base, crc32_nx, crc16_nx;
  ptr_t        wr_q, wr_d, cm_q, cm_d, rd_q, wr_inc;
  logic        commit_q, commit_d;
  logic        ok_q, ok_d, bad_q, bad_d, ovf_q, ovf_d;
  logic [15:0] drop_q;
  logic        drop_inc, we, we_err, crc_pass, new_frame, full;
  logic [31:0] wdata;
  logic [33:0] mem_q [DEPTH];  // {last, err, data}

  // CRC: a frame's first beat is seeded from RegIni instead of crc_q
  always_comb begin
    new_frame = (state_q == IDLE) || (state_q == CHECK);
    crc_base  = new_frame ? RegIni : crc_q;
    crc32_nx  = crc_base;
    for (int i = 31; i >= 0; i--) crc32_nx = crc_step(crc32_nx, Din[i]);
    crc16_nx  = crc_base;
    for (int i = 31; i >= 16; i--) crc16_nx = crc_step(crc16_nx, Din[i]);
    crc_pass  = (crc16_nx == Din[15:0]);
  end

  assign wr_inc = wr_q + ptr_t'(1);
  assign full   = (wr_inc == rd_q);
  assign wdata  = DinLast ? {Din[31:16], 16'h0000} : Din;

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    wr_d     = wr_q;
    cm_d     = cm_q;
    commit_d = 1'b0;
    ok_d     = 1'b0;
    bad_d    = 1'b0;
    ovf_d    = 1'b0;
    drop_inc = 1'b0;
    we       = 1'b0;
    we_err   = 1'b0;
    // Commit of the previous frame happens in CHECK; any rollback this
    // cycle must target the post-commit pointer, hence cm_d below.
    if (state_q == CHECK && commit_q) cm_d = wr_q;
    if (DinNd) begin
      if (state_q == DISCARD) begin
        if (DinLast) begin
          bad_d    = 1'b1;
          drop_inc = 1'b1;
          state_d  = CHECK;
        end
      end else if (full) begin
        ovf_d = 1'b1;
        wr_d  = cm_d;
        if (DinLast) begin
          bad_d    = 1'b1;
          drop_inc = 1'b1;
          state_d  = CHECK;
        end else begin
          state_d = DISCARD;
        end
      end else begin
        we   = 1'b1;
        wr_d = wr_inc;
        if (DinLast) begin
          state_d = CHECK;
          ok_d    = crc_pass;
          bad_d   = ~crc_pass;
`ifdef CRC_RX_DROP_BAD_EN
          if (crc_pass) begin
            commit_d = 1'b1;
          end else begin
            wr_d     = cm_d;
            drop_inc = 1'b1;
          end
`else
          commit_d = 1'b1;
          we_err   = ~crc_pass;
`endif
        end else begin
          state_d = FRAME;
          crc_d   = crc32_nx;
        end
      end
    end else if (state_q == CHECK) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!RstN) begin
      state_q  <= IDLE;
      crc_q    <= 16'hFFFF;
      wr_q     <= '0;
      cm_q     <= '0;
      commit_q <= 1'b0;
      ok_q     <= 1'b0;
      bad_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      wr_q     <= wr_d;
      cm_q     <= cm_d;
      commit_q <= commit_d;
      ok_q     <= ok_d;
      bad_q    <= bad_d;
      ovf_q    <= ovf_d;
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_q] <= {DinLast, we_err, wdata};
  end

  // Read side: single output register, refilled from committed words only
  logic        dv_q, dlast_q, derr_q;
  logic [31:0] dout_q;
  logic [3:0]  keep_q;
  logic [33:0] rword;
  logic        load;

  assign rword = mem_q[rd_q];
  assign load  = (rd_q != cm_q) && (!dv_q || DoutRdy);

  always_ff @(posedge clk) begin
    if (!RstN) begin
      dv_q    <= 1'b0;
      dout_q  <= '0;
      keep_q  <= '0;
      dlast_q <= 1'b0;
      derr_q  <= 1'b0;
      rd_q    <= '0;
    end else if (load) begin
      dv_q    <= 1'b1;
      dout_q  <= rword[31:0];
      derr_q  <= rword[32];
      dlast_q <= rword[33];
      keep_q  <= rword[33] ? 4'hC : 4'hF;
      rd_q    <= rd_q + ptr_t'(1);
    end else if (DoutRdy) begin
      dv_q <= 1'b0;
    end
  end

  assign DoutNd   = dv_q;
  assign Dout     = dout_q;
  assign DoutKeep = keep_q;
  assign DoutLast = dlast_q;
  assign DoutErr  = derr_q;
  assign FrameOk  = ok_q;
  assign FrameBad = bad_q;
  assign Overflow = ovf_q;
  assign DropCnt  = drop_q;
endmodule

// File: tb/tb_crc16_rx_strip.sv
module tb_crc16_rx_strip;
  localparam int DL2 = 3;
`ifdef CRC_RX_DROP_BAD_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RstN, DinNd, DinLast, DoutNd, DoutRdy, DoutLast, DoutErr;
  logic        FrameOk, FrameBad, Overflow;
  logic [15:0] RegIni, DropCnt;
  logic [31:0] Din, Dout;
  logic [3:0]  DoutKeep;

  crc16_rx_strip #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .RstN(RstN), .RegIni(RegIni), .DinNd(DinNd), .Din(Din),
    .DinLast(DinLast), .DoutNd(DoutNd), .DoutRdy(DoutRdy), .Dout(Dout),
    .DoutKeep(DoutKeep), .DoutLast(DoutLast), .DoutErr(DoutErr),
    .FrameOk(FrameOk), .FrameBad(FrameBad), .Overflow(Overflow), .DropCnt(DropCnt)
  );

  int          n_chk = 0, n_fail = 0;
  logic [37:0] exp_q [$];   // {err, last, keep, data}
  logic [31:0] frm [$];
  logic [15:0] exp_drop;
  bit          mon_en = 1'b0, stalled = 1'b0;
  logic [37:0] held, cur;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [31:0] d, input int n);
    logic fb;
    for (int i = 31; i > 31 - n; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Output monitor: scoreboard pop plus stability while stalled
  always @(negedge clk) begin
    if (mon_en && RstN) begin
      cur = {DoutErr, DoutLast, DoutKeep, Dout};
      if (stalled) begin
        chk("hold_vld", 64'(DoutNd), 64'(1'b1));
        chk("hold_data", 64'(cur), 64'(held));
      end
      if (DoutNd && DoutRdy) begin
        if (exp_q.size() == 0) chk("unexpected_out", 64'(DoutNd), 64'(1'b0));
        else chk("out_word", 64'(cur), 64'(exp_q.pop_front()));
      end
      stalled = DoutNd && !DoutRdy;
      held    = cur;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic mk_frame(input int n, input logic [15:0] ini, input bit bad);
    logic [15:0] c, hi;
    frm.delete();
    for (int i = 0; i < n - 1; i++) frm.push_back($urandom());
    hi = 16'($urandom());
    c  = ini;
    for (int i = 0; i < n - 1; i++) c = m_crc(c, frm[i], 32);
    c = m_crc(c, {hi, 16'h0000}, 16);
    frm.push_back({hi, c ^ {15'b0, bad}});
  endtask

  // Drives frm as one frame; ovf_at = beat index expected to overflow (-1: none)
  task automatic send_frame(input logic [15:0] ini, input int ovf_at);
    int          n;
    logic [15:0] c;
    bit          pass, ovf;
    n = frm.size();
    c = ini;
    for (int i = 0; i < n - 1; i++) c = m_crc(c, frm[i], 32);
    c    = m_crc(c, frm[n-1], 16);
    pass = (c == frm[n-1][15:0]);
    ovf  = (ovf_at >= 0);
    if (!ovf && (pass || !DROP))
      for (int i = 0; i < n; i++)
        exp_q.push_back((i == n - 1) ? {!pass, 1'b1, 4'hC, frm[i][31:16], 16'h0000}
                                     : {1'b0, 1'b0, 4'hF, frm[i]});
    if ((ovf || (!pass && DROP)) && exp_drop != 16'hFFFF) exp_drop++;
    for (int i = 0; i < n; i++) begin
      RegIni  = ini;
      DinNd   = 1'b1;
      Din     = frm[i];
      DinLast = (i == n - 1);
      @(posedge clk); #1;
      chk("overflow", 64'(Overflow), 64'(i == ovf_at));
      if (i == n - 1) begin
        chk("frame_ok", 64'(FrameOk), 64'(!ovf && pass));
        chk("frame_bad", 64'(FrameBad), 64'(ovf || !pass));
        chk("drop_cnt", 64'(DropCnt), 64'(exp_drop));
      end else begin
        chk("no_status", 64'({FrameOk, FrameBad}), 64'(0));
      end
    end
    DinNd   = 1'b0;
    DinLast = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      DoutRdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    DoutRdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, 64'({DoutNd, DoutErr, DoutLast, DoutKeep, Dout, FrameOk, FrameBad,
                  Overflow, DropCnt}), 64'(0));
  endtask

  initial begin
    RstN = 1'b0; RegIni = '0; DinNd = 1'b0; Din = '0; DinLast = 1'b0;
    DoutRdy = 1'b1; exp_drop = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset_outs");
    RstN = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;

    // single-word pass with fall-through latency
    frm = '{32'h0001_1021};
    send_frame(16'h0000, -1);
    chk("ft_t1_vld", 64'(DoutNd), 64'(1'b0));
    @(posedge clk); #1;
    chk("ft_t2_vld", 64'(DoutNd), 64'(1'b0));
    @(posedge clk); #1;
    chk("ft_t3_vld", 64'(DoutNd), 64'(1'b1));
    chk("ft_t3_word", 64'({DoutErr, DoutLast, DoutKeep, Dout}),
        64'({1'b0, 1'b1, 4'hC, 32'h0001_0000}));
    drain(1'b0);

    // single-word fail
    frm = '{32'h0001_1020};
    send_frame(16'h0000, -1);
    drain(1'b0);

    // multi-word all zero
    frm = '{32'h0, 32'h0, 32'h0};
    send_frame(16'h0000, -1);
    drain(1'b0);

    // backpressure on the same frame
    DoutRdy = 1'b0;
    frm = '{32'h0, 32'h0, 32'h0};
    send_frame(16'h0000, -1);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_vld", 64'(DoutNd), 64'(1'b1));
    drain(1'b0);

    // overflow: 8-entry buffer, nothing drained, 10-word frame
    DoutRdy = 1'b0;
    frm.delete();
    for (int i = 0; i < 10; i++) frm.push_back($urandom());
    send_frame(16'h0000, 7);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_no_out", 64'(DoutNd), 64'(1'b0));
    mk_frame(2, 16'h1234, 1'b0);
    send_frame(16'h1234, -1);
    drain(1'b0);

    // back-to-back frames, some bad
    for (int k = 0; k < 6; k++) begin
      logic [15:0] ini;
      ini = 16'($urandom());
      mk_frame(int'($urandom_range(1, 3)), ini, (k % 3) == 2);
      send_frame(ini, -1);
    end
    drain(1'b0);

    // isolated frames with random downstream ready
    for (int k = 0; k < 4; k++) begin
      logic [15:0] ini;
      ini = 16'($urandom());
      mk_frame(int'($urandom_range(1, 3)), ini, k == 1);
      send_frame(ini, -1);
      drain(1'b1);
    end

    // reset mid-frame
    RegIni = 16'h5555; DinNd = 1'b1; DinLast = 1'b0; Din = $urandom();
    @(posedge clk); #1;
    Din = $urandom();
    @(posedge clk); #1;
    DinNd = 1'b0; RstN = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("midrst_outs");
    exp_drop = '0;
    RstN = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_status", 64'({FrameOk, FrameBad, Overflow}), 64'(0));
    mk_frame(2, 16'hBEEF, 1'b0);
    send_frame(16'hBEEF, -1);
    drain(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
